// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of the IF/ID, register-file, write-back and ID/EX
//               signals around the decode stage. The master modport is the
//               surrounding pipeline. The slave modport is the decode stage.
//   IF/ID in   : if_valid, if_instr, if_pc4, flush
//   RF         : rf_read_reg1/2 (to RF), rf_read_data1/2 (from RF)
//   WB         : wb_reg_write, wb_write_reg, wb_write_data
//   Status     : stall, illegal_instr
//   ID/EX out  : ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs,
//                ex_rt, ex_dst, ex_alu_op and the control bits
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [DATA_W-1:0] if_pc4;
  logic              flush;
  logic [ADDR_W-1:0] rf_read_reg1;
  logic [ADDR_W-1:0] rf_read_reg2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              stall;
  logic              illegal_instr;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_alu_src;
  logic              ex_branch;
  logic              ex_jump;
  logic [2:0]        ex_alu_op;

  modport master (
    output if_valid, if_instr, if_pc4, flush,
    input  rf_read_reg1, rf_read_reg2,
    output rf_read_data1, rf_read_data2,
    output wb_reg_write, wb_write_reg, wb_write_data,
    input  stall, illegal_instr,
    input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  ex_alu_src, ex_branch, ex_jump, ex_alu_op
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, flush,
    output rf_read_reg1, rf_read_reg2,
    input  rf_read_data1, rf_read_data2,
    input  wb_reg_write, wb_write_reg, wb_write_data,
    output stall, illegal_instr,
    output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output ex_alu_src, ex_branch, ex_jump, ex_alu_op
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : MIPS decode stage plus the ID/EX pipeline register. It
//               decodes control, extends the immediate, bypasses same-cycle
//               WB writes, detects load-use hazards and applies EX flushes.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - id_ex_stage_if.slave (IF/ID, RF, WB and ID/EX signals)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // R-type function codes
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_LUI  = 3'd5;

  // Instruction fields
  logic [5:0]        op;
  logic [5:0]        fn;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;

  assign op = bus.if_instr[31:26];
  assign fn = bus.if_instr[5:0];
  assign rs = bus.if_instr[25:21];
  assign rt = bus.if_instr[20:16];
  assign rd = bus.if_instr[15:11];

  assign bus.rf_read_reg1 = rs;
  assign bus.rf_read_reg2 = rt;

  // Decoded control
  logic              dec_legal;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_mem_to_reg;
  logic              dec_alu_src;
  logic              dec_branch;
  logic              dec_jump;
  logic [2:0]        dec_alu_op;
  logic [ADDR_W-1:0] dec_dst;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_reads_rt;

  always_comb begin
    dec_legal      = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_dst        = '0;
    dec_imm        = {{(DATA_W-16){bus.if_instr[15]}}, bus.if_instr[15:0]};
    dec_reads_rt   = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_reads_rt  = 1'b1;
        dec_dst       = rd;
        dec_reg_write = 1'b1;
        dec_legal     = 1'b1;
        case (fn)
          FN_ADD:  dec_alu_op = ALU_ADD;
          FN_SUB:  dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          FN_SLT:  dec_alu_op = ALU_SLT;
          default: dec_legal  = 1'b0;
        endcase
      end
      OP_LW: begin
        dec_legal      = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_dst        = rt;
      end
      OP_SW: begin
        dec_legal     = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_reads_rt  = 1'b1;
      end
      OP_BEQ: begin
        dec_legal    = 1'b1;
        dec_branch   = 1'b1;
        dec_alu_op   = ALU_SUB;
        dec_reads_rt = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec_legal     = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_dst       = rt;
        case (op)
          OP_SLTI: dec_alu_op = ALU_SLT;
          OP_ANDI: begin
            dec_alu_op = ALU_AND;
            dec_imm    = {{(DATA_W-16){1'b0}}, bus.if_instr[15:0]};
          end
          OP_ORI: begin
            dec_alu_op = ALU_OR;
            dec_imm    = {{(DATA_W-16){1'b0}}, bus.if_instr[15:0]};
          end
          OP_LUI: begin
            dec_alu_op = ALU_LUI;
            dec_imm    = {bus.if_instr[15:0], {(DATA_W-16){1'b0}}};
          end
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OP_J: begin
        dec_legal = 1'b1;
        dec_jump  = 1'b1;
        // Word-aligned target without the PC region bits; EX merges those in.
        dec_imm   = {{(DATA_W-28){1'b0}}, bus.if_instr[25:0], 2'b00};
      end
      default: dec_legal = 1'b0;
    endcase
    // Writes to $0 are architecturally discarded, so never request them.
    if (dec_dst == '0) begin
      dec_reg_write = 1'b0;
    end
  end

  // Register-file read data with same-cycle WB bypass. The RF read is
  // combinational and misses a write landing on this edge; $0 is hardwired.
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  always_comb begin
    rs_data = bus.rf_read_data1;
    rt_data = bus.rf_read_data2;
    if (rs == '0) begin
      rs_data = '0;
    end else if (bus.wb_reg_write && (bus.wb_write_reg == rs)) begin
      rs_data = bus.wb_write_data;
    end
    if (rt == '0) begin
      rt_data = '0;
    end else if (bus.wb_reg_write && (bus.wb_write_reg == rt)) begin
      rt_data = bus.wb_write_data;
    end
  end

  // ID/EX register state
  logic              ex_valid_q,      ex_valid_d;
  logic              ex_reg_write_q,  ex_reg_write_d;
  logic              ex_mem_read_q,   ex_mem_read_d;
  logic              ex_mem_write_q,  ex_mem_write_d;
  logic              ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic              ex_alu_src_q,    ex_alu_src_d;
  logic              ex_branch_q,     ex_branch_d;
  logic              ex_jump_q,       ex_jump_d;
  logic [2:0]        ex_alu_op_q,     ex_alu_op_d;
  logic              illegal_q,       illegal_d;
  logic [DATA_W-1:0] ex_pc4_q;
  logic [DATA_W-1:0] ex_rs_data_q;
  logic [DATA_W-1:0] ex_rt_data_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [ADDR_W-1:0] ex_rs_q;
  logic [ADDR_W-1:0] ex_rt_q;
  logic [ADDR_W-1:0] ex_dst_q;

  // Load-use hazard: the load in EX produces its value too late for this
  // instruction. The bubble it inserts clears ex_valid, so it lasts one cycle.
  logic hazard;
  logic stall_w;
  logic accept;

  assign hazard = bus.if_valid && ex_valid_q && ex_mem_read_q && (ex_rt_q != '0) &&
                  ((ex_rt_q == rs) || (dec_reads_rt && (ex_rt_q == rt)));
  assign stall_w = hazard && !bus.flush;
  assign accept  = bus.if_valid && !bus.flush && !stall_w;

  always_comb begin
    ex_valid_d      = accept && dec_legal;
    illegal_d       = accept && !dec_legal;
    ex_reg_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_alu_src_d    = 1'b0;
    ex_branch_d     = 1'b0;
    ex_jump_d       = 1'b0;
    ex_alu_op_d     = 3'd0;
    if (ex_valid_d) begin
      ex_reg_write_d  = dec_reg_write;
      ex_mem_read_d   = dec_mem_read;
      ex_mem_write_d  = dec_mem_write;
      ex_mem_to_reg_d = dec_mem_to_reg;
      ex_alu_src_d    = dec_alu_src;
      ex_branch_d     = dec_branch;
      ex_jump_d       = dec_jump;
      ex_alu_op_d     = dec_alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      illegal_q       <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_jump_q       <= 1'b0;
      ex_alu_op_q     <= 3'd0;
      ex_pc4_q        <= '0;
      ex_rs_data_q    <= '0;
      ex_rt_data_q    <= '0;
      ex_imm_q        <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dst_q        <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      illegal_q       <= illegal_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_branch_q     <= ex_branch_d;
      ex_jump_q       <= ex_jump_d;
      ex_alu_op_q     <= ex_alu_op_d;
      // Payload is don't-care under a bubble, so it loads unconditionally.
      ex_pc4_q        <= bus.if_pc4;
      ex_rs_data_q    <= rs_data;
      ex_rt_data_q    <= rt_data;
      ex_imm_q        <= dec_imm;
      ex_rs_q         <= rs;
      ex_rt_q         <= rt;
      ex_dst_q        <= dec_dst;
    end
  end

  assign bus.stall         = stall_w;
  assign bus.illegal_instr = illegal_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc4        = ex_pc4_q;
  assign bus.ex_rs_data    = ex_rs_data_q;
  assign bus.ex_rt_data    = ex_rt_data_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_rs         = ex_rs_q;
  assign bus.ex_rt         = ex_rt_q;
  assign bus.ex_dst        = ex_dst_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
  assign bus.ex_alu_src    = ex_alu_src_q;
  assign bus.ex_branch     = ex_branch_q;
  assign bus.ex_jump       = ex_jump_q;
  assign bus.ex_alu_op     = ex_alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A table of instruction
//               vectors with expected ID/EX results is driven in order; the
//               expectations are queued at drive time and checked one cycle
//               later. Hand-written sequences cover reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Check-group flags for payload fields that are defined for a vector
  localparam logic [2:0] C_DST  = 3'b001;
  localparam logic [2:0] C_IMM  = 3'b010;
  localparam logic [2:0] C_DATA = 3'b100;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl packing: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        e_stall;
    logic        e_valid;
    logic        e_ill;
    logic [6:0]  e_ctrl;
    logic [2:0]  e_op;
    logic [4:0]  e_dst;
    logic [31:0] e_imm;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [2:0]  chk;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic flush,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                              input logic e_stall, input logic e_valid, input logic e_ill,
                              input logic [6:0] e_ctrl, input logic [2:0] e_op,
                              input logic [4:0] e_dst, input logic [31:0] e_imm,
                              input logic [31:0] e_rs, input logic [31:0] e_rt,
                              input logic [2:0] chk);
    vec_t v;
    v.instr = instr;  v.valid = valid;  v.flush = flush;
    v.rd1 = rd1;      v.rd2 = rd2;
    v.wbe = wbe;      v.wbr = wbr;      v.wbd = wbd;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_ill = e_ill;
    v.e_ctrl = e_ctrl;   v.e_op = e_op;       v.e_dst = e_dst;
    v.e_imm = e_imm;     v.e_rs = e_rs;       v.e_rt = e_rt;
    v.chk = chk;         v.pc4 = 32'h0;
    return v;
  endfunction

  // Ordinary legal instruction, no WB activity, rf data 5/7
  function automatic vec_t ok(input logic [31:0] instr, input logic [6:0] ctrl, input logic [2:0] op,
                              input logic [4:0] dst, input logic [31:0] imm,
                              input logic [31:0] rsd, input logic [31:0] rtd, input logic [2:0] chk);
    return mk(instr, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
              1'b0, 1'b1, 1'b0, ctrl, op, dst, imm, rsd, rtd, chk);
  endfunction

  // Instruction expected to be turned into a bubble
  function automatic vec_t bub(input logic [31:0] instr, input logic valid, input logic flush,
                               input logic e_stall, input logic e_ill);
    return mk(instr, valid, flush, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0,
              e_stall, 1'b0, e_ill, 7'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_valid      = v.valid;
    bus.if_instr      = v.instr;
    bus.if_pc4        = v.pc4;
    bus.flush         = v.flush;
    bus.rf_read_data1 = v.rd1;
    bus.rf_read_data2 = v.rd2;
    bus.wb_reg_write  = v.wbe;
    bus.wb_write_reg  = v.wbr;
    bus.wb_write_data = v.wbd;
  endtask

  // Drive one vector, check combinational stall, then check the ID/EX
  // register one edge later against the queued expectation.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    v.pc4 = 32'h0000_1000 + 32'(idx) * 32'd4;
    drive(v);
    #1;
    chk("stall", idx, {31'd0, bus.stall}, {31'd0, v.e_stall});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ex_valid", idx, {31'd0, bus.ex_valid}, {31'd0, e.e_valid});
    chk("illegal_instr", idx, {31'd0, bus.illegal_instr}, {31'd0, e.e_ill});
    chk("ctrl", idx, {25'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                      bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_branch, bus.ex_jump},
        {25'd0, e.e_ctrl});
    chk("ex_alu_op", idx, {29'd0, bus.ex_alu_op}, {29'd0, e.e_op});
    if (e.e_valid) begin
      chk("ex_pc4", idx, bus.ex_pc4, e.pc4);
    end
    if (e.chk[0]) begin
      chk("ex_dst", idx, {27'd0, bus.ex_dst}, {27'd0, e.e_dst});
    end
    if (e.chk[1]) begin
      chk("ex_imm", idx, bus.ex_imm, e.e_imm);
    end
    if (e.chk[2]) begin
      chk("ex_rs_data", idx, bus.ex_rs_data, e.e_rs);
      chk("ex_rt_data", idx, bus.ex_rt_data, e.e_rt);
      chk("ex_rs", idx, {27'd0, bus.ex_rs}, {27'd0, e.instr[25:21]});
      chk("ex_rt", idx, {27'd0, bus.ex_rt}, {27'd0, e.instr[20:16]});
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ex_valid"}, -1, {31'd0, bus.ex_valid}, 32'd0);
    chk({nm, " illegal"}, -1, {31'd0, bus.illegal_instr}, 32'd0);
    chk({nm, " stall"}, -1, {31'd0, bus.stall}, 32'd0);
    chk({nm, " ctrl"}, -1, {25'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                            bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_branch, bus.ex_jump}, 32'd0);
    chk({nm, " payload"}, -1, bus.ex_pc4 | bus.ex_rs_data | bus.ex_rt_data | bus.ex_imm |
                             {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_dst, 29'd0 == 29'd0 ? bus.ex_alu_op[0] : 1'b0},
        32'd0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw  $2,4($1)
  localparam logic [31:0] I_USE  = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] I_SW   = 32'hAC22_0008; // sw  $2,8($1)
  localparam logic [6:0]  K_R    = 7'b1000000;
  localparam logic [6:0]  K_I    = 7'b1000100;
  localparam logic [6:0]  K_LW   = 7'b1101100;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    drive(bub(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    tbl.push_back(ok(I_ADD,        K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(ok(32'h0022_4022, K_R, 3'd1, 5'd8, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(ok(32'h0022_4024, K_R, 3'd2, 5'd8, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(ok(32'h0022_4025, K_R, 3'd3, 5'd8, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(ok(32'h0022_402A, K_R, 3'd4, 5'd8, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(bub(32'h0022_4021, 1'b1, 1'b0, 1'b0, 1'b1));           // unsupported funct
    tbl.push_back(ok(I_ADD,        K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    tbl.push_back(ok(32'h2020_0003, 7'b0000100, 3'd0, 5'd0, 32'd3, 32'd5, 32'd0, 3'b111)); // addi $0
    tbl.push_back(mk(32'h2003_FFFF, 1'b1, 1'b0, 32'h99, 32'd7, 1'b0, 5'd0, 32'd0,
                     1'b0, 1'b1, 1'b0, K_I, 3'd0, 5'd3, 32'hFFFF_FFFF, 32'd0, 32'd7, 3'b111));
    tbl.push_back(ok(32'h3405_FFFF, K_I, 3'd3, 5'd5, 32'h0000_FFFF, 32'd0, 32'd7, 3'b111)); // ori
    tbl.push_back(ok(32'h2824_FFFE, K_I, 3'd4, 5'd4, 32'hFFFF_FFFE, 32'd5, 32'd7, 3'b111)); // slti
    tbl.push_back(ok(32'h3026_8000, K_I, 3'd2, 5'd6, 32'h0000_8000, 32'd5, 32'd7, 3'b111)); // andi
    tbl.push_back(ok(32'h3C07_1234, K_I, 3'd5, 5'd7, 32'h1234_0000, 32'd0, 32'd7, 3'b111)); // lui
    tbl.push_back(ok(32'h0810_0000, 7'b0000001, 3'd0, 5'd0, 32'h0040_0000, 32'd0, 32'd0, C_IMM)); // j
    tbl.push_back(ok(32'h1022_FFFF, 7'b0000010, 3'd1, 5'd0, 32'h0, 32'd5, 32'd7, C_DATA)); // beq
    tbl.push_back(ok(I_SW, 7'b0010100, 3'd0, 5'd0, 32'd8, 32'd5, 32'd7, C_IMM | C_DATA));
    // load-use on rs: one stall cycle, then the retry issues
    tbl.push_back(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111));
    tbl.push_back(bub(I_USE, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(ok(I_USE, K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    // load-use on rt via sw
    tbl.push_back(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111));
    tbl.push_back(bub(I_SW, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(ok(I_SW, 7'b0010100, 3'd0, 5'd0, 32'd8, 32'd5, 32'd7, C_IMM | C_DATA));
    // addi $3,$0,1 after lw $2 reads neither $2 operand: no stall
    tbl.push_back(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111));
    tbl.push_back(mk(32'h2003_0001, 1'b1, 1'b0, 32'h99, 32'd7, 1'b0, 5'd0, 32'd0,
                     1'b0, 1'b1, 1'b0, K_I, 3'd0, 5'd3, 32'd1, 32'd0, 32'd7, 3'b111));
    // flush overrides a load-use hazard
    tbl.push_back(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111));
    tbl.push_back(bub(I_USE, 1'b1, 1'b1, 1'b0, 1'b0));
    // invalid IF/ID never stalls
    tbl.push_back(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111));
    tbl.push_back(bub(I_USE, 1'b0, 1'b0, 1'b0, 1'b0));
    // lw into $0 cannot create a hazard
    tbl.push_back(ok(32'h8C20_0004, 7'b0101100, 3'd0, 5'd0, 32'd4, 32'd5, 32'd0, 3'b111));
    tbl.push_back(ok(32'h0000_1820, K_R, 3'd0, 5'd3, 32'h0, 32'd0, 32'd0, C_DST | C_DATA));
    // WB bypass on rs, on rt, suppressed for $0 and when write disabled
    tbl.push_back(mk(I_ADD, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd1, 32'hDEAD_BEEF,
                     1'b0, 1'b1, 1'b0, K_R, 3'd0, 5'd3, 32'h0, 32'hDEAD_BEEF, 32'd7, C_DST | C_DATA));
    tbl.push_back(mk(I_ADD, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd2, 32'h0000_CAFE,
                     1'b0, 1'b1, 1'b0, K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'h0000_CAFE, C_DST | C_DATA));
    tbl.push_back(mk(32'h0002_1820, 1'b1, 1'b0, 32'h55, 32'd7, 1'b1, 5'd0, 32'h1234,
                     1'b0, 1'b1, 1'b0, K_R, 3'd0, 5'd3, 32'h0, 32'd0, 32'd7, C_DST | C_DATA));
    tbl.push_back(mk(I_ADD, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0, 5'd1, 32'hDEAD_0000,
                     1'b0, 1'b1, 1'b0, K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));
    // illegal opcode: flushed ones do not pulse; accepted one pulses once
    tbl.push_back(bub(32'hFC00_0000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(bub(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(ok(I_ADD, K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Asynchronous reset in the middle of a stall cycle
    apply(ok(I_LW, K_LW, 3'd0, 5'd2, 32'd4, 32'd5, 32'd7, 3'b111), 100);
    drive(bub(I_USE, 1'b1, 1'b0, 1'b1, 1'b0));
    #1;
    chk("pre-reset stall", 101, {31'd0, bus.stall}, 32'd1);
    chk("pre-reset ex_mem_read", 101, {31'd0, bus.ex_mem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(posedge clk);
    #1;
    chk_all_zero("held reset");
    rst_n = 1'b1;
    // The pending hazard must not survive reset
    apply(ok(I_USE, K_R, 3'd0, 5'd3, 32'h0, 32'd5, 32'd7, C_DST | C_DATA), 102);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard residue: got %0d entries want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register for the 5-stage MIPS core.
- Consumes the IF/ID instruction and drives the register file read addresses; captures the read data in the same cycle.
- Decodes control and sign/zero-extends the immediate, then registers everything for EX.
- Detects load-use hazards (stall plus bubble), applies EX-requested flushes, and bypasses same-cycle WB writes. The register file's read is combinational, so a value written at the edge is not visible to a read in the same cycle; this stage covers that case.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  one clock; reset is asynchronous and active-low
- if_valid  input  1  IF/ID holds a valid instruction
- if_instr  input  32  instruction
- if_pc4  input  32  PC+4 of that instruction
- flush  input  1  branch/jump resolved in EX; kill the instruction in ID
- rf_read_reg1  output  5  instr[25:21] (rs), combinational
- rf_read_reg2  output  5  instr[20:16] (rt), combinational
- rf_read_data1  input  32  register file data for rs
- rf_read_data2  input  32  register file data for rt
- wb_reg_write  input  1  WB write enable
- wb_write_reg  input  5  WB destination
- wb_write_data  input  32  WB data
- stall  output  1  combinational; IF must hold PC and IF/ID
- illegal_instr  output  1  registered one-cycle pulse: unsupported opcode/funct accepted
- ex_valid, ex_pc4[32], ex_rs_data[32], ex_rt_data[32], ex_imm[32], ex_rs[5], ex_rt[5], ex_dst[5]  outputs  registered ID/EX payload
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump  outputs  1 each, registered control
- ex_alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LUI

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0 and illegal_instr is 0. stall is 0 while reset is asserted. Reset asserted mid-stall clears the pending bubble; no state survives.
- Decode, where op=instr[31:26] and fn=instr[5:0]:
  - R-type (op 0x00), fn 0x20 add / 0x22 sub / 0x24 and / 0x25 or / 0x2A slt: dst=rd, reg_write=1, alu_src=0.
  - lw (0x23): mem_read=1, mem_to_reg=1, reg_write=1, dst=rt, alu_src=1, ADD.
  - sw (0x2B): mem_write=1, alu_src=1, ADD.
  - beq (0x04): branch=1, SUB.
  - addi (0x08): ADD. slti (0x0A): SLT. Both use a sign-extended immediate.
  - andi (0x0C): AND. ori (0x0D): OR. Both use a zero-extended immediate.
  - lui (0x0F): LUI, with imm={instr[15:0],16'h0}. For all I-type ALU ops: dst=rt, reg_write=1, alu_src=1.
  - j (0x02): jump=1; ex_imm = {4'b0, instr[25:0], 2'b00}, and EX merges the upper PC bits.
- $0 rule: if the decoded dst==0, ex_reg_write=0.
- Any other op/fn: captured as a bubble (valid=0, all control 0), illegal_instr=1 for one cycle.
- Bypass: if wb_reg_write && wb_write_reg!=0 && wb_write_reg==rs, ex_rs_data captures wb_write_data instead of rf_read_data1. The same rule applies to rt and ex_rt_data. Register $0 always captures 0.
- Load-use hazard (combinational stall), all of the following true:
  - if_valid && ex_valid && ex_mem_read && ex_rt!=0
  - ex_rt==rs, or ex_rt==rt where the instruction reads rt (R-type, sw, beq).
  - In that case stall=1 and ID/EX captures a bubble; the instruction is retried next cycle.
- Register update priority at each rising edge:
  1. flush: capture a bubble and force stall=0 (stall is gated by !flush). illegal_instr=0.
  2. stall: capture a bubble.
  3. !if_valid: capture a bubble.
  4. Otherwise: load the decoded payload with ex_valid=1.
- A bubble clears valid and all control bits; payload fields may hold any value.
- Latency: exactly 1 cycle from an IF/ID instruction to ex_*. Throughput is 1 per cycle except 1 lost cycle per load-use stall.
- A stall never lasts more than 1 consecutive cycle, because the bubble removes the hazard source.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with a valid lw in ID -> all ex_* and illegal_instr go 0 immediately, not waiting for clk; stall=0.
- add $3,$1,$2 (0x00221820) with rf data 5/7 -> next cycle ex_valid=1, ex_dst=3, ex_alu_op=0, ex_reg_write=1, ex_rs_data=5, ex_rt_data=7.
- lw $2,4($1) then add $3,$2,$4 -> stall=1 for one cycle and ex_valid=0. The add is issued the following cycle. addi $3,$0,1 after the lw -> no stall.
- WB writes $1=0xDEAD_BEEF in the same cycle ID reads $1 -> ex_rs_data=0xDEADBEEF. WB write to $0 with data 0x1234 while ID reads $0 -> ex_rs_data=0.
- flush=1 in a cycle that also has a load-use hazard -> stall=0 and a bubble is captured. Next: ori $5,$0,0xFFFF -> ex_imm=0x0000FFFF. addi with imm 0xFFFF -> ex_imm=0xFFFFFFFF.
- op 0x3F -> illegal_instr high for exactly one cycle, ex_valid=0. addi $0,$1,3 -> ex_valid=1, ex_reg_write=0.
